// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: function codes and FSM states.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_IMUL = 2'b01,
    MD_DIV  = 2'b10,
    MD_IDIV = 2'b11
  } md_func_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } md_state_e;

  function automatic logic md_is_div(input md_func_e f);
    return (f == MD_DIV) || (f == MD_IDIV);
  endfunction

  function automatic logic md_is_signed(input md_func_e f);
    return (f == MD_IMUL) || (f == MD_IDIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add (multiply) or restoring-subtract (divide) iteration on unsigned magnitudes.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] i_part,
  input  logic [WIDTH-1:0]   i_operand,
  input  logic               i_bit,
  input  logic               i_div,
  output logic [2*WIDTH-1:0] o_part,
  output logic               o_qbit
);

  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;

  always_comb begin
    // Partial remainder always stays below the divisor, so WIDTH bits hold it.
    w_trial = {i_part[WIDTH-1:0], i_bit};
    w_diff  = w_trial - {1'b0, i_operand};
    o_qbit  = 1'b0;
    if (i_div) begin
      o_qbit = (w_trial >= {1'b0, i_operand});
      o_part = o_qbit ? {{(WIDTH-1){1'b0}}, w_diff} : {{(WIDTH-1){1'b0}}, w_trial};
    end else begin
      o_part = {i_part[2*WIDTH-2:0], 1'b0} + (i_bit ? {{WIDTH{1'b0}}, i_operand} : '0);
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MUL/IMUL/DIV/IDIV unit, one result bit per clock, word or byte operand size.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [1:0]         i_func,
  input  logic               i_word,
  input  logic [2*WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0]   i_operand,
  output logic [WIDTH-1:0]   o_result_lo,
  output logic [WIDTH-1:0]   o_result_hi,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_div_exc,
  output logic               o_mul_ovf
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   LO_MASK  = {{H{1'b0}}, {H{1'b1}}};
  localparam logic [2*WIDTH-1:0] DW_MASK  = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
  localparam logic [CW-1:0]      CNT_WORD = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_BYTE = CW'(H - 1);

  md_state_e          r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_part;
  logic [WIDTH-1:0]   r_opa, r_oper, r_quo;
  logic               r_signed, r_div, r_word, r_neg_res, r_neg_rem, r_ovf_pre, r_dz_pend;
  logic [WIDTH-1:0]   r_lo, r_hi;
  logic               r_busy, r_done, r_exc, r_ovf;

  md_func_e           w_func;
  logic               w_signed, w_is_div;
  logic [WIDTH-1:0]   w_a_sx, w_b_sx, w_a_mag, w_b_mag, w_d_hi, w_d_lo;
  logic [2*WIDTH-1:0] w_d_sx, w_d_mag;
  logic               w_a_neg, w_b_neg, w_d_neg, w_div_zero, w_ovf_pre;

  assign w_func   = md_func_e'(i_func);
  assign w_signed = md_is_signed(w_func);
  assign w_is_div = md_is_div(w_func);

  always_comb begin
    if (i_word) begin
      w_a_sx = i_dividend[WIDTH-1:0];
      w_b_sx = i_operand;
      w_d_sx = i_dividend;
    end else begin
      w_a_sx = {{H{i_dividend[H-1]}}, i_dividend[H-1:0]};
      w_b_sx = {{H{i_operand[H-1]}}, i_operand[H-1:0]};
      w_d_sx = {{WIDTH{i_dividend[WIDTH-1]}}, i_dividend[WIDTH-1:0]};
    end
    w_a_neg = w_signed & w_a_sx[WIDTH-1];
    w_b_neg = w_signed & w_b_sx[WIDTH-1];
    w_d_neg = w_signed & w_d_sx[2*WIDTH-1];
    w_a_mag = w_a_neg ? -w_a_sx : w_a_sx;
    w_b_mag = w_b_neg ? -w_b_sx : w_b_sx;
    w_d_mag = w_d_neg ? -w_d_sx : w_d_sx;
    // Masking drops sign-extension bits for unsigned byte ops; magnitudes always fit N bits.
    if (!i_word) begin
      w_a_mag = w_a_mag & LO_MASK;
      w_b_mag = w_b_mag & LO_MASK;
      w_d_mag = w_d_mag & DW_MASK;
      w_d_hi  = {{H{1'b0}}, w_d_mag[WIDTH-1:H]};
      w_d_lo  = {{H{1'b0}}, w_d_mag[H-1:0]};
    end else begin
      w_d_hi  = w_d_mag[2*WIDTH-1:WIDTH];
      w_d_lo  = w_d_mag[WIDTH-1:0];
    end
    w_div_zero = (w_b_mag == '0);
    w_ovf_pre  = (w_d_hi >= w_b_mag);
  end

  logic [2*WIDTH-1:0] w_step_part;
  logic               w_step_q;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_part    (r_part),
    .i_operand (r_oper),
    .i_bit     (r_opa[r_cnt]),
    .i_div     (r_div),
    .o_part    (w_step_part),
    .o_qbit    (w_step_q)
  );

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_mul_lo, w_mul_hi;
  logic               w_mul_ovf, w_q_big, w_div_ovf;

  always_comb begin
    w_prod = r_neg_res ? -r_part : r_part;
    w_quo  = r_neg_res ? -r_quo : r_quo;
    w_rem  = r_neg_rem ? -r_part[WIDTH-1:0] : r_part[WIDTH-1:0];
    if (r_word) begin
      w_mul_lo  = w_prod[WIDTH-1:0];
      w_mul_hi  = w_prod[2*WIDTH-1:WIDTH];
      w_mul_ovf = r_signed ? (w_mul_hi != {WIDTH{w_mul_lo[WIDTH-1]}}) : (w_mul_hi != '0);
      w_q_big   = r_quo[WIDTH-1];
    end else begin
      w_mul_lo  = {{H{1'b0}}, w_prod[H-1:0]};
      w_mul_hi  = {{H{1'b0}}, w_prod[WIDTH-1:H]};
      w_mul_ovf = r_signed ? (w_prod[WIDTH-1:H] != {H{w_prod[H-1]}})
                           : (w_prod[WIDTH-1:H] != '0);
      w_q_big   = r_quo[H-1];
      w_quo     = w_quo & LO_MASK;
      w_rem     = w_rem & LO_MASK;
    end
    // Signed limit also rejects the most-negative quotient.
    w_div_ovf = r_ovf_pre | (r_signed & w_q_big);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_part    <= '0;
      r_opa     <= '0;
      r_oper    <= '0;
      r_quo     <= '0;
      r_signed  <= 1'b0;
      r_div     <= 1'b0;
      r_word    <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_ovf_pre <= 1'b0;
      r_dz_pend <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_exc     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (r_dz_pend) begin
            r_dz_pend <= 1'b0;
            r_exc     <= 1'b1;
            r_done    <= 1'b1;
          end else if (i_start) begin
            r_exc     <= 1'b0;
            r_ovf     <= 1'b0;
            r_signed  <= w_signed;
            r_div     <= w_is_div;
            r_word    <= i_word;
            r_cnt     <= i_word ? CNT_WORD : CNT_BYTE;
            r_part    <= w_is_div ? {{WIDTH{1'b0}}, w_d_hi} : '0;
            r_opa     <= w_is_div ? w_d_lo : w_b_mag;
            r_oper    <= w_is_div ? w_b_mag : w_a_mag;
            r_quo     <= '0;
            r_neg_res <= w_is_div ? (w_d_neg ^ w_b_neg) : (w_a_neg ^ w_b_neg);
            r_neg_rem <= w_d_neg;
            r_ovf_pre <= w_ovf_pre;
            if (w_is_div && w_div_zero) begin
              r_dz_pend <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_part <= w_step_part;
          r_quo  <= {r_quo[WIDTH-2:0], w_step_q};
          if (r_cnt == '0) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (r_div) begin
            if (w_div_ovf) begin
              r_exc <= 1'b1;
            end else begin
              r_lo <= w_quo;
              r_hi <= w_rem;
            end
          end else begin
            r_lo  <= w_mul_lo;
            r_hi  <= w_mul_hi;
            r_ovf <= w_mul_ovf;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_result_lo = r_lo;
  assign o_result_hi = r_hi;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_div_exc   = r_exc;
  assign o_mul_ovf   = r_ovf;

endmodule
